// File: rtl/fas_pkg.sv
// Shared FAS front-end definitions: scheduler FSM states, job status codes, data geometry.
package fas_pkg;

    localparam int unsigned FAS_DW    = 16;
    localparam int unsigned FAS_FRAME = 32;

    // Per-job status reported alongside done
    localparam logic [1:0] ERR_OK       = 2'd0;
    localparam logic [1:0] ERR_UNDERRUN = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_SHORT    = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StGrant,
        StLoad,
        StWait,
        StDrain,
        StDone
    } fas_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: search starts one past ptr and wraps.
module rr_arbiter #(
    parameter int unsigned NREQ = 2
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         pick,
    output logic                    any
);

    localparam int unsigned PW = $clog2(NREQ);

    // First set request at or after ptr+1 (mod NREQ) wins
    always_comb begin
        logic          found;
        logic [PW-1:0] idx;
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        any   = |req;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            idx = PW'((32'(ptr) + off) % NREQ);
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fir_job_sched.sv
// Shares one FIR engine between NREQ sources: grants a source, streams its frame gap-free
// into the engine, returns the filtered frame, and watches the engine for stalls.
module fir_job_sched
    import fas_pkg::*;
#(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned FRAME   = FAS_FRAME,
    parameter int unsigned DW      = FAS_DW,
    parameter int unsigned TIMEOUT = 2048
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] src_data,
    input  logic [NREQ-1:0]    src_valid,
    output logic [NREQ-1:0]    gnt,
    output logic               busy,
    output logic [DW-1:0]      fir_data,
    output logic               fir_data_valid,
    output logic               fir_srst,
    input  logic [DW-1:0]      fir_d,
    input  logic               fir_valid,
    output logic [DW-1:0]      out_data,
    output logic [NREQ-1:0]    out_valid,
    output logic [NREQ-1:0]    done,
    output logic [1:0]         err
);

    localparam int unsigned PW = $clog2(NREQ);
    localparam int unsigned CW = $clog2(FRAME) + 1;
    localparam int unsigned WW = $clog2(TIMEOUT + 1);

    fas_state_e       state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WW-1:0]    wdog_q, wdog_d;
    logic             under_q, under_d;
    logic [1:0]       jerr_q, jerr_d;
    logic [DW-1:0]    fir_data_q, fir_data_d;
    logic             fdv_q, fdv_d;
    logic             srst_q, srst_d;
    logic [DW-1:0]    out_data_q, out_data_d;
    logic [NREQ-1:0]  out_valid_q, out_valid_d;
    logic [NREQ-1:0]  done_q, done_d;
    logic [1:0]       err_q, err_d;

    logic [NREQ-1:0]  pick;
    logic             any_req;
    logic [DW-1:0]    g_data;
    logic             g_valid;
    logic [PW-1:0]    g_idx;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req  (req),
        .ptr  (ptr_q),
        .pick (pick),
        .any  (any_req)
    );

    // Select the granted source's sample stream and its index
    always_comb begin
        g_data  = '0;
        g_valid = 1'b0;
        g_idx   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_q[i]) begin
                g_data  = src_data[i*DW +: DW];
                g_valid = src_valid[i];
                g_idx   = PW'(i);
            end
        end
    end

    // Job FSM: next state, counters, watchdog and registered-output next values
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        cnt_d       = cnt_q;
        wdog_d      = wdog_q;
        under_d     = under_q;
        jerr_d      = jerr_q;
        fir_data_d  = '0;
        fdv_d       = 1'b0;
        srst_d      = 1'b0;
        out_data_d  = '0;
        out_valid_d = '0;
        done_d      = '0;
        err_d       = ERR_OK;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    gnt_d   = pick;
                    cnt_d   = '0;
                    wdog_d  = '0;
                    under_d = 1'b0;
                    jerr_d  = ERR_OK;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                if (g_valid) begin
                    fir_data_d = g_data;
                    fdv_d      = 1'b1;
                    cnt_d      = CW'(1);
                    state_d    = StLoad;
                end else if (wdog_q == WW'(TIMEOUT - 1)) begin
                    // Engine never started, so no engine reset is needed
                    jerr_d  = ERR_TIMEOUT;
                    state_d = StDone;
                end else begin
                    wdog_d = wdog_q + WW'(1);
                end
            end
            StLoad: begin
                // Engine cannot stall: a missing sample is sent as zero
                fdv_d      = 1'b1;
                fir_data_d = g_valid ? g_data : '0;
                if (!g_valid) begin
                    under_d = 1'b1;
                end
                if (cnt_q == CW'(FRAME - 1)) begin
                    cnt_d   = '0;
                    wdog_d  = '0;
                    state_d = StWait;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StWait: begin
                if (fir_valid) begin
                    out_data_d  = fir_d;
                    out_valid_d = gnt_q;
                    cnt_d       = CW'(1);
                    state_d     = StDrain;
                end else if (wdog_q == WW'(TIMEOUT - 1)) begin
                    srst_d  = 1'b1;
                    jerr_d  = ERR_TIMEOUT;
                    state_d = StDone;
                end else begin
                    wdog_d = wdog_q + WW'(1);
                end
            end
            StDrain: begin
                if (fir_valid) begin
                    out_data_d  = fir_d;
                    out_valid_d = gnt_q;
                    if (cnt_q == CW'(FRAME - 1)) begin
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    srst_d  = 1'b1;
                    jerr_d  = ERR_SHORT;
                    state_d = StDone;
                end
            end
            StDone: begin
                // Timeout/short outrank the sticky underrun flag
                done_d  = gnt_q;
                err_d   = (jerr_q != ERR_OK) ? jerr_q : (under_q ? ERR_UNDERRUN : ERR_OK);
                gnt_d   = '0;
                ptr_d   = g_idx;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            ptr_q       <= PW'(NREQ - 1);
            gnt_q       <= '0;
            cnt_q       <= '0;
            wdog_q      <= '0;
            under_q     <= 1'b0;
            jerr_q      <= ERR_OK;
            fir_data_q  <= '0;
            fdv_q       <= 1'b0;
            srst_q      <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= '0;
            done_q      <= '0;
            err_q       <= ERR_OK;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            cnt_q       <= cnt_d;
            wdog_q      <= wdog_d;
            under_q     <= under_d;
            jerr_q      <= jerr_d;
            fir_data_q  <= fir_data_d;
            fdv_q       <= fdv_d;
            srst_q      <= srst_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign gnt            = gnt_q;
    assign busy           = (state_q != StIdle);
    assign fir_data       = fir_data_q;
    assign fir_data_valid = fdv_q;
    assign fir_srst       = srst_q;
    assign out_data       = out_data_q;
    assign out_valid      = out_valid_q;
    assign done           = done_q;
    assign err            = err_q;

endmodule

// File: tb/tb_fir_job_sched.sv
// Bench for fir_job_sched: job table plus randomized jobs against a job-level model.
module tb_fir_job_sched;
    import fas_pkg::*;

    localparam int NREQ  = 2;
    localparam int DW    = 16;
    localparam int FRAME = 32;
    localparam int TMO   = 64;

    typedef struct {
        logic [NREQ-1:0] rq;
        int              under;
        int              echo;
        bit              no_valid;
        bit              drop;
        logic [NREQ-1:0] egnt;
        logic [1:0]      eerr;
    } job_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NREQ-1:0]    req = '0;
    logic [NREQ*DW-1:0] src_data = '0;
    logic [NREQ-1:0]    src_valid = '0;
    logic [DW-1:0]      fir_d = '0;
    logic               fir_valid = 1'b0;
    logic [NREQ-1:0]    gnt;
    logic               busy;
    logic [DW-1:0]      fir_data;
    logic               fir_data_valid;
    logic               fir_srst;
    logic [DW-1:0]      out_data;
    logic [NREQ-1:0]    out_valid;
    logic [NREQ-1:0]    done;
    logic [1:0]         err;

    int cyc = 0;
    int n_pass = 0;
    int n_total = 0;
    int mptr = NREQ - 1;
    job_t tbl[13];

    fir_job_sched #(
        .NREQ    (NREQ),
        .FRAME   (FRAME),
        .DW      (DW),
        .TIMEOUT (TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .src_data       (src_data),
        .src_valid      (src_valid),
        .gnt            (gnt),
        .busy           (busy),
        .fir_data       (fir_data),
        .fir_data_valid (fir_data_valid),
        .fir_srst       (fir_srst),
        .fir_d          (fir_d),
        .fir_valid      (fir_valid),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .done           (done),
        .err            (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // Engine stand-in: a fixed byte-swap/xor so output data depends on every input bit
    function automatic logic [DW-1:0] eng_f(input logic [DW-1:0] x);
        return {x[7:0], x[15:8]} ^ 16'h3c5a;
    endfunction

    function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] r, input int p);
        for (int off = 1; off <= NREQ; off++) begin
            int idx;
            idx = (p + off) % NREQ;
            if (r[idx]) return NREQ'(1) << idx;
        end
        return '0;
    endfunction

    function automatic logic [1:0] model_err(input job_t j);
        if (j.no_valid || j.echo == 0) return ERR_TIMEOUT;
        if (j.echo < FRAME) return ERR_SHORT;
        if (j.under >= 0) return ERR_UNDERRUN;
        return ERR_OK;
    endfunction

    task automatic run_job(input job_t j);
        int g = -1, gcyc = 0, delay = 0, k = 0;
        logic [DW-1:0] exp_in[$];
        logic [DW-1:0] act_in[$];
        logic [DW-1:0] act_out[$];
        int first_drive = -1, first_in = -1, last_in = -1;
        bit in_gap = 0, bad_dst = 0;
        int eng_wait = -1, eng_left, eng_idx = 0, first_eng = -1;
        int first_out = -1, last_out = -1, srst_cnt = 0, srst_cyc = -1;
        logic [NREQ-1:0] dval = '0;
        logic [1:0] derr = '0;
        int dcyc = -1, exp_n, bad;
        eng_left = j.echo;
        req = j.rq;
        src_valid = '0;
        fir_valid = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (g < 0 && gnt != 0) begin
                for (int i = 0; i < NREQ; i++) if (gnt[i]) g = i;
                gcyc = cyc;
                chk("gnt", gnt, j.egnt);
                chk("busy_at_grant", busy, 1);
                delay = $urandom_range(0, 3);
                if (j.drop) req = '0;
            end
            if (fir_data_valid) begin
                if (last_in >= 0 && last_in != cyc - 1) in_gap = 1;
                if (first_in < 0) first_in = cyc;
                last_in = cyc;
                act_in.push_back(fir_data);
                if (act_in.size() == FRAME) eng_wait = 3;
            end
            if (out_valid != 0) begin
                if (g < 0 || out_valid != (NREQ'(1) << g)) bad_dst = 1;
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                act_out.push_back(out_data);
            end
            if (fir_srst) begin
                srst_cnt++;
                if (srst_cyc < 0) srst_cyc = cyc;
                eng_left = 0;
                eng_wait = -1;
            end
            if (done != 0) begin
                dval = done;
                derr = err;
                dcyc = cyc;
                chk("gnt_clear_at_done", gnt, 0);
                break;
            end
            // Drive next cycle: noise on every source, real frame on the granted one
            src_valid = NREQ'($urandom);
            src_data = $urandom;
            if (g >= 0) begin
                src_valid[g] = 1'b0;
                if (!j.no_valid && k < FRAME) begin
                    if (delay > 0) delay--;
                    else begin
                        logic [DW-1:0] v;
                        v = DW'($urandom);
                        src_data[g*DW +: DW] = v;
                        src_valid[g] = (k != j.under);
                        exp_in.push_back((k != j.under) ? v : '0);
                        if (k == 0) first_drive = cyc;
                        k++;
                    end
                end
            end
            fir_valid = 1'b0;
            fir_d = DW'($urandom);
            if (eng_wait > 0) eng_wait--;
            else if (eng_wait == 0 && eng_left > 0) begin
                fir_valid = 1'b1;
                fir_d = eng_f(act_in[eng_idx]);
                if (first_eng < 0) first_eng = cyc;
                eng_idx++;
                eng_left--;
            end
        end
        src_valid = '0;
        fir_valid = 1'b0;
        chk("granted", (g >= 0), 1);
        chk("done_seen", (dcyc >= 0), 1);
        if (g >= 0 && dcyc >= 0) begin
            chk("done", dval, j.egnt);
            chk("err", derr, j.eerr);
            if (!j.no_valid) begin
                chk("in_count", act_in.size(), FRAME);
                bad = 0;
                for (int i = 0; i < FRAME; i++)
                    if (i >= act_in.size() || act_in[i] !== exp_in[i]) bad++;
                chk("in_data_bad", bad, 0);
                chk("in_gap", in_gap, 0);
                chk("in_latency", first_in - first_drive, 1);
            end else begin
                chk("no_input", act_in.size(), 0);
                chk("grant_timeout_lat", dcyc - gcyc, TMO + 1);
                chk("grant_timeout_srst", srst_cnt, 0);
            end
            exp_n = j.no_valid ? 0 : ((j.echo < FRAME) ? j.echo : FRAME);
            chk("out_count", act_out.size(), exp_n);
            bad = 0;
            for (int i = 0; i < exp_n; i++)
                if (i >= act_out.size() || act_out[i] !== eng_f(exp_in[i])) bad++;
            chk("out_data_bad", bad, 0);
            chk("out_dest", bad_dst, 0);
            if (!j.no_valid && j.echo >= FRAME) begin
                chk("out_latency", first_out - first_eng, 1);
                chk("done_latency", dcyc - last_out, 1);
                chk("srst_none", srst_cnt, 0);
            end else if (!j.no_valid && j.echo == 0) begin
                chk("srst_count", srst_cnt, 1);
                chk("wait_timeout_lat", srst_cyc - last_in, TMO);
            end else if (!j.no_valid) begin
                chk("srst_count", srst_cnt, 1);
                chk("short_srst_lat", srst_cyc - last_out, 1);
            end
            mptr = g;
        end
    endtask

    initial begin
        job_t j;
        bit gs;
        //          rq     under echo nv drop egnt   eerr
        tbl[0]  = '{2'b01, -1, 32, 1'b0, 1'b0, 2'b01, ERR_OK};
        tbl[1]  = '{2'b10, -1, 32, 1'b0, 1'b1, 2'b10, ERR_OK};
        tbl[2]  = '{2'b11, -1, 32, 1'b0, 1'b0, 2'b01, ERR_OK};
        tbl[3]  = '{2'b11, -1, 32, 1'b0, 1'b0, 2'b10, ERR_OK};
        tbl[4]  = '{2'b11, -1, 32, 1'b0, 1'b0, 2'b01, ERR_OK};
        tbl[5]  = '{2'b11, -1, 32, 1'b0, 1'b0, 2'b10, ERR_OK};
        tbl[6]  = '{2'b01, 10, 32, 1'b0, 1'b0, 2'b01, ERR_UNDERRUN};
        tbl[7]  = '{2'b11, -1,  0, 1'b0, 1'b0, 2'b10, ERR_TIMEOUT};
        tbl[8]  = '{2'b11, -1, 32, 1'b0, 1'b0, 2'b01, ERR_OK};
        tbl[9]  = '{2'b01, -1, 20, 1'b0, 1'b0, 2'b01, ERR_SHORT};
        tbl[10] = '{2'b10, -1, 32, 1'b1, 1'b0, 2'b10, ERR_TIMEOUT};
        tbl[11] = '{2'b10,  5, 20, 1'b0, 1'b0, 2'b10, ERR_SHORT};
        tbl[12] = '{2'b01, 31,  0, 1'b0, 1'b0, 2'b01, ERR_TIMEOUT};

        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fir", {fir_data, fir_data_valid, fir_srst}, 0);
        chk("rst_out", {out_data, out_valid, done, err}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) run_job(tbl[i]);

        for (int r = 0; r < 8; r++) begin
            int sel;
            j.rq = NREQ'($urandom_range(1, 3));
            j.under = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 31)) : -1;
            sel = $urandom_range(0, 5);
            j.echo = (sel == 0) ? 0 : (sel == 1) ? int'($urandom_range(1, 31)) : FRAME;
            j.no_valid = ($urandom_range(0, 9) == 0);
            j.drop = $urandom_range(0, 1);
            j.egnt = rr_pick(j.rq, mptr);
            j.eerr = model_err(j);
            run_job(j);
        end

        // Asynchronous reset partway through a frame load
        req = 2'b01;
        gs = 0;
        for (int n = 0; n < 10 && !gs; n++) begin
            @(negedge clk);
            if (gnt != 0) gs = 1;
        end
        chk("rstmid_gnt", gnt, 2'b01);
        for (int s = 0; s < 15; s++) begin
            src_valid = 2'b01;
            src_data[DW-1:0] = DW'(s + 1);
            @(negedge clk);
        end
        chk("rstmid_loading", {busy, fir_data_valid}, 2'b11);
        rst = 1'b1;
        src_valid = '0;
        req = '0;
        #1;
        chk("rstmid_gnt_zero", gnt, 0);
        chk("rstmid_busy_zero", busy, 0);
        chk("rstmid_fir_zero", {fir_data, fir_data_valid, fir_srst}, 0);
        chk("rstmid_out_zero", {out_data, out_valid, done, err}, 0);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("rstmid_no_done", done, 0);
        end
        rst = 1'b0;
        mptr = NREQ - 1;
        j = '{2'b11, -1, 32, 1'b0, 1'b0, 2'b01, ERR_OK};
        run_job(j);
        req = '0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fir_job_sched.md
# fir_job_sched

Round-robin scheduler that shares the single 32-tap FIR engine between NREQ sample sources in the FAS front end. A granted source streams one frame of FRAME samples, which the block forwards to the engine. The block then collects the engine's FRAME filtered outputs and routes them back to the same source. It enforces the engine's gap-free input rule, runs a watchdog on the engine, and reports underrun and timeout errors.

## Interface
- NREQ, 2: number of requesters, 2..8.
- FRAME, 32: samples per job; must equal the FIR engine's tap/frame length.
- DW, 16: sample width.
- TIMEOUT, 2048: maximum cycles allowed in WAIT or GRANT before abort.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req  in  NREQ  per-source job request, level.
- src_data  in  NREQ*DW  per-source sample; source i occupies bits [i*DW +: DW].
- src_valid  in  NREQ  per-source sample strobe.
- gnt  out  NREQ  one-hot grant, held for the whole job.
- busy  out  1  high from GRANT through DONE.
- fir_data  out  DW  sample to the FIR engine `data`.
- fir_data_valid  out  1  to the FIR engine `data_valid`.
- fir_srst  out  1  one-cycle engine reset pulse on abort; OR-ed into the engine's rst at top level.
- fir_d  in  DW  engine output sample.
- fir_valid  in  1  engine output strobe.
- out_data  out  DW  filtered sample returned to the granted source.
- out_valid  out  NREQ  per-source output strobe.
- done  out  NREQ  one-cycle job-complete pulse.
- err  out  2  per-job status, valid with done: 0 ok, 1 underrun, 2 timeout, 3 short output.

## Operation
- FSM states: IDLE, GRANT, LOAD, WAIT, DRAIN, DONE.
- IDLE: if any req is set, the round-robin pick becomes the grant and the FSM goes to GRANT. The pick starts searching at ptr+1 mod NREQ. ptr resets to NREQ-1, so source 0 wins first.
- GRANT: gnt is high. The first cycle with src_valid[g]=1 captures sample 0 and moves the FSM to LOAD.
  - The watchdog counts GRANT cycles.
  - On reaching TIMEOUT: err=2, go to DONE. No fir_srst is issued, because the engine was never started.
- LOAD: captures samples 1..FRAME-1, one per cycle, unconditionally.
  - If src_valid[g]=0 in a LOAD cycle, the block forwards 0 and sets a sticky underrun flag (err=1 at done).
  - The frame always completes, because the engine cannot be stalled.
  - After the FRAME-th sample, go to WAIT.
- WAIT: the watchdog restarts at 0.
  - fir_valid=1: go to DRAIN; that cycle's output counts as output 0.
  - TIMEOUT reached: pulse fir_srst, set err=2, go to DONE.
- DRAIN: forwards each fir_valid cycle.
  - After FRAME outputs, go to DONE.
  - If fir_valid falls before FRAME outputs have been forwarded: err=3, pulse fir_srst, go to DONE.
- DONE: for one cycle, done[g]=1 and err is valid. Then gnt clears, ptr<=g, go to IDLE.
- err priority: timeout > short > underrun.
- A source dropping req mid-job is ignored; the job runs to completion.
- A new req seen in DONE waits for IDLE (minimum 1 idle cycle between jobs).
- src_valid and src_data of non-granted sources are ignored.
- Counters:
  - sample/output counter: $clog2(FRAME)+1 bits.
  - watchdog: $clog2(TIMEOUT+1) bits.
  - No wrap: counters clear on every state entry.

## Timing
- Reset values: gnt, fir_data, fir_data_valid, fir_srst, out_data, out_valid, done, err and busy are all 0. FSM is in IDLE; ptr=NREQ-1.
- Asynchronous reset mid-job returns the block to IDLE immediately, with no done pulse.
- Request to grant: gnt rises 1 cycle after req is sampled in IDLE.
- Input path: fir_data and fir_data_valid are registered, 1 cycle after capture. fir_data_valid is high for exactly FRAME consecutive cycles per job.
- Output path: out_data and out_valid[g] are registered, 1 cycle after fir_valid.
- done fires 1 cycle after the last out_valid.
- fir_srst is registered, exactly 1 cycle wide.

## Structure
- Shared package fas_pkg holds:
  - the FSM state enum;
  - err code constants (ERR_OK, ERR_UNDERRUN, ERR_TIMEOUT, ERR_SHORT);
  - FAS_DW=16 and FAS_FRAME=32.
- One sub-module, rr_arbiter: combinational round-robin pick from req and ptr, producing a one-hot result plus an any flag. Parameterised by NREQ.
- The top of this block holds the FSM, counters, watchdog, input/output muxing and output registers.

## Test plan
- Single job: req[0]=1, source 0 streams 1..32 with src_valid continuous; engine model echoes 32 outputs.
  -> gnt=01; fir_data_valid high for 32 cycles carrying 1..32; out_valid[0] 32 times; done[0] pulse; err=0.
- Fairness: req=11 held for 4 jobs.
  -> grants occur in the order 0,1,0,1; each job's outputs appear only on its own out_valid bit.
- Underrun: src_valid[0] low on sample 10.
  -> fir_data=0 in that slot; fir_data_valid still 32 contiguous cycles; done with err=1.
- Engine timeout: engine model never asserts fir_valid, TIMEOUT=64.
  -> fir_srst pulse exactly 64 cycles after WAIT entry; done[g] with err=2; gnt cleared; next requester served normally.
- Short output: engine model asserts fir_valid for only 20 cycles.
  -> 20 out_valid pulses; fir_srst pulse; err=3.
- Reset mid-LOAD: rst asserted at sample 15.
  -> all outputs 0 immediately; no done pulse; after release, source 0 is granted first again.
